// File: rtl/psdifir_mac_sched.sv
// Sequencer that time-shares one MAC between the left and right channels of a
// circular-buffer FIR: writes each frame, sweeps all taps per channel, latches results.
module psdifir_mac_sched #(
  parameter int NTAPS    = 16384,
  parameter int AW       = 14,
  parameter int PIPE_LAT = 3,
  parameter int DW       = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            datain_ready,
  input  logic [DW-1:0]   left_in,
  input  logic [DW-1:0]   right_in,
  output logic            smp_wr_en,
  output logic [AW-1:0]   smp_wr_addr,
  output logic [2*DW-1:0] smp_wr_data,
  output logic [AW-1:0]   smp_rd_addr,
  output logic            smp_rd_ch,
  output logic [AW-1:0]   coef_rd_addr,
  output logic            mac_en,
  output logic            mac_clear,
  input  logic [DW-1:0]   mac_result,
  output logic [DW-1:0]   left_out,
  output logic [DW-1:0]   right_out,
  output logic            dataout_ready,
  output logic            busy,
  output logic            overrun
);
  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [3:0] {
    INIT, IDLE, WRITE, MAC_L, DRAIN_L, STORE_L, MAC_R, DRAIN_R, STORE_R, DONE
  } state_t;

  // state_reg is the state whose outputs are currently on the output registers
  state_t         state_reg, state_next;
  logic [AW-1:0]  k_reg, k_next;
  logic [DCW-1:0] dcnt_reg, dcnt_next;
  logic [AW-1:0]  wp_reg, wp_next;

  logic            wr_en_next;
  logic [AW-1:0]   wr_addr_next;
  logic [2*DW-1:0] wr_data_next;
  logic [AW-1:0]   rd_addr_next;
  logic            rd_ch_next;
  logic [AW-1:0]   coef_addr_next;
  logic            mac_en_next;
  logic            mac_clear_next;
  logic            ready_next;
  logic            busy_next;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    dcnt_next  = dcnt_reg;
    wp_next    = wp_reg;
    case (state_reg)
      INIT:    if (smp_wr_en && smp_wr_addr == AW'(NTAPS - 1)) state_next = IDLE;
      IDLE:    if (datain_ready) state_next = WRITE;
      WRITE: begin
        state_next = MAC_L;
        k_next     = '0;
      end
      MAC_L, MAC_R: begin
        if (k_reg == AW'(NTAPS - 1)) begin
          state_next = (state_reg == MAC_L) ? DRAIN_L : DRAIN_R;
          dcnt_next  = '0;
        end else begin
          k_next = k_reg + AW'(1);
        end
      end
      DRAIN_L, DRAIN_R: begin
        if (dcnt_reg == DCW'(PIPE_LAT - 1))
          state_next = (state_reg == DRAIN_L) ? STORE_L : STORE_R;
        else
          dcnt_next = dcnt_reg + DCW'(1);
      end
      STORE_L: begin
        state_next = MAC_R;
        k_next     = '0;
      end
      STORE_R: state_next = DONE;
      DONE: begin
        state_next = IDLE;
        wp_next    = wp_reg + AW'(1);
      end
      default: state_next = INIT;
    endcase
  end

  // Output registers are loaded with the decode of the state being entered.
  always_comb begin
    wr_en_next     = 1'b0;
    wr_addr_next   = '0;
    wr_data_next   = '0;
    rd_addr_next   = '0;
    rd_ch_next     = 1'b0;
    coef_addr_next = '0;
    mac_en_next    = 1'b0;
    mac_clear_next = 1'b0;
    ready_next     = 1'b0;
    busy_next      = (state_next != IDLE);
    case (state_next)
      INIT: begin
        // A cleared write enable marks the first sweep cycle after reset
        wr_en_next   = 1'b1;
        wr_addr_next = smp_wr_en ? smp_wr_addr + AW'(1) : '0;
      end
      WRITE: begin
        wr_en_next   = 1'b1;
        wr_addr_next = wp_reg;
        wr_data_next = {left_in, right_in};
      end
      MAC_L, MAC_R: begin
        rd_addr_next   = wp_reg - k_next;
        coef_addr_next = k_next;
        rd_ch_next     = (state_next == MAC_R);
        mac_en_next    = 1'b1;
        mac_clear_next = (k_next == '0);
      end
      DRAIN_R, STORE_R: rd_ch_next = 1'b1;
      DONE:             ready_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= INIT;
      k_reg         <= '0;
      dcnt_reg      <= '0;
      wp_reg        <= '0;
      smp_wr_en     <= 1'b0;
      smp_wr_addr   <= '0;
      smp_wr_data   <= '0;
      smp_rd_addr   <= '0;
      smp_rd_ch     <= 1'b0;
      coef_rd_addr  <= '0;
      mac_en        <= 1'b0;
      mac_clear     <= 1'b0;
      left_out      <= '0;
      right_out     <= '0;
      dataout_ready <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      dcnt_reg      <= dcnt_next;
      wp_reg        <= wp_next;
      smp_wr_en     <= wr_en_next;
      smp_wr_addr   <= wr_addr_next;
      smp_wr_data   <= wr_data_next;
      smp_rd_addr   <= rd_addr_next;
      smp_rd_ch     <= rd_ch_next;
      coef_rd_addr  <= coef_addr_next;
      mac_en        <= mac_en_next;
      mac_clear     <= mac_clear_next;
      dataout_ready <= ready_next;
      busy          <= busy_next;
      if (state_reg == STORE_L) left_out <= mac_result;
      if (state_reg == STORE_R) right_out <= mac_result;
      if (datain_ready && state_reg != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psdifir_mac_sched.sv
// Directed bench for psdifir_mac_sched with an 8-tap, 2-cycle-latency configuration;
// expected values come from the cycle map of a frame, indexed from the accepting edge.
module tb_psdifir_mac_sched;
  localparam int NTAPS = 8;
  localparam int AW = 3;
  localparam int PIPE_LAT = 2;
  localparam int DW = 18;

  logic            clock;
  logic            reset;
  logic            datain_ready;
  logic [DW-1:0]   left_in;
  logic [DW-1:0]   right_in;
  logic            smp_wr_en;
  logic [AW-1:0]   smp_wr_addr;
  logic [2*DW-1:0] smp_wr_data;
  logic [AW-1:0]   smp_rd_addr;
  logic            smp_rd_ch;
  logic [AW-1:0]   coef_rd_addr;
  logic            mac_en;
  logic            mac_clear;
  logic [DW-1:0]   mac_result;
  logic [DW-1:0]   left_out;
  logic [DW-1:0]   right_out;
  logic            dataout_ready;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_left;
  logic [DW-1:0] exp_right;

  wire [87:0] all_out = {smp_wr_en, smp_wr_addr, smp_wr_data, smp_rd_addr, smp_rd_ch,
                         coef_rd_addr, mac_en, mac_clear, left_out, right_out,
                         dataout_ready, busy, overrun};

  psdifir_mac_sched #(.NTAPS(NTAPS), .AW(AW), .PIPE_LAT(PIPE_LAT), .DW(DW)) dut (
    .clock(clock), .reset(reset), .datain_ready(datain_ready),
    .left_in(left_in), .right_in(right_in),
    .smp_wr_en(smp_wr_en), .smp_wr_addr(smp_wr_addr), .smp_wr_data(smp_wr_data),
    .smp_rd_addr(smp_rd_addr), .smp_rd_ch(smp_rd_ch), .coef_rd_addr(coef_rd_addr),
    .mac_en(mac_en), .mac_clear(mac_clear), .mac_result(mac_result),
    .left_out(left_out), .right_out(right_out), .dataout_ready(dataout_ready),
    .busy(busy), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    datain_ready = 1'b0;
    left_in = '0;
    right_in = '0;
    mac_result = 18'h2AAAA;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    $display("reset held: outputs %h", all_out);
    reset = 1'b0;
    exp_left = '0;
    exp_right = '0;
  endtask

  // Expects reset to have just been released at #1 after an edge.
  task automatic test_init();
    logic [41:0] obs, exp;
    for (int i = 0; i < NTAPS; i++) begin
      @(posedge clock);
      #1;
      obs = {smp_wr_en, smp_wr_addr, smp_wr_data, mac_en, busy};
      exp = {1'b1, 3'(i), 36'd0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL init_write i=%0d got %h want %h", i, obs, exp);
      end
      $display("init cycle %0d: wr_en=%b addr=%0d busy=%b", i, smp_wr_en, smp_wr_addr, busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL init_done_idle got %h want 0", all_out);
    end
  endtask

  // One full frame; call at #1 after an edge with the DUT in IDLE.
  // inj_at: observed cycle at which an extra strobe is driven (0 = none).
  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [AW-1:0] wp_exp, input logic [DW-1:0] base,
                           input int inj_at, input logic ovr_before);
    logic [5:0] ctrl_obs, ctrl_exp;
    logic [AW-1:0] k, rd_exp;
    logic ch;
    logic ovr_exp;
    left_in = l;
    right_in = r;
    datain_ready = 1'b1;
    mac_result = base;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clock);
      #1;
      datain_ready = (inj_at == c);
      if (inj_at == c) begin
        left_in = ~l;
        right_in = ~r;
      end
      mac_result = base + 18'(c);

      ovr_exp = ovr_before | (inj_at != 0 && c > inj_at);
      ctrl_obs = {smp_wr_en, mac_en, mac_clear, dataout_ready, busy, overrun};
      ctrl_exp = {c == 1, (c >= 2 && c <= 9) || (c >= 13 && c <= 20),
                  c == 2 || c == 13, c == 24, c <= 24, ovr_exp};
      checks++;
      if (ctrl_obs !== ctrl_exp) begin
        errors++;
        $display("FAIL frame_ctrl wp=%0d c=%0d got %b want %b", wp_exp, c, ctrl_obs, ctrl_exp);
      end

      if (c == 1) begin
        checks++;
        if ({smp_wr_addr, smp_wr_data} !== {wp_exp, l, r}) begin
          errors++;
          $display("FAIL frame_write got addr %0d data %h want addr %0d data %h",
                   smp_wr_addr, smp_wr_data, wp_exp, {l, r});
        end
      end

      if ((c >= 2 && c <= 9) || (c >= 13 && c <= 20)) begin
        k = (c <= 9) ? 3'(c - 2) : 3'(c - 13);
        ch = (c >= 13);
        rd_exp = wp_exp - k;
        checks++;
        if ({smp_rd_addr, coef_rd_addr, smp_rd_ch} !== {rd_exp, k, ch}) begin
          errors++;
          $display("FAIL frame_read c=%0d got rd=%0d coef=%0d ch=%b want rd=%0d coef=%0d ch=%b",
                   c, smp_rd_addr, coef_rd_addr, smp_rd_ch, rd_exp, k, ch);
        end
      end

      if (c == 12 || c == 13) begin
        if (c == 13) exp_left = base + 18'd12;
        checks++;
        if (left_out !== exp_left) begin
          errors++;
          $display("FAIL left_out c=%0d got %h want %h", c, left_out, exp_left);
        end
      end
      if (c == 23 || c == 24) begin
        if (c == 24) exp_right = base + 18'd23;
        checks++;
        if ({left_out, right_out} !== {exp_left, exp_right}) begin
          errors++;
          $display("FAIL right_out c=%0d got %h/%h want %h/%h",
                   c, left_out, right_out, exp_left, exp_right);
        end
      end
    end
    $display("frame wp=%0d in=%h/%h out=%h/%h overrun=%b",
             wp_exp, l, r, left_out, right_out, overrun);
  endtask

  task automatic test_frame();
    run_frame(18'h00010, 18'h3FFF0, 3'd0, 18'h01000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 1; f <= 8; f++)
      run_frame(18'(f * 3), 18'h3FFFF - 18'(f), 3'(f), 18'(18'h02000 + f * 256), 0, 1'b0);
  endtask

  task automatic test_overrun();
    run_frame(18'h1ABCD, 18'h05432, 3'd1, 18'h03000, 5, 1'b0);
    run_frame(18'h00777, 18'h10101, 3'd2, 18'h03400, 0, 1'b1);
  endtask

  task automatic test_reset_midframe();
    left_in = 18'h12345;
    right_in = 18'h06789;
    datain_ready = 1'b1;
    mac_result = 18'h04000;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      datain_ready = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL midframe_reset got %h want 0", all_out);
    end
    $display("reset at cycle 10: outputs %h", all_out);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_left = '0;
    exp_right = '0;
    test_init();
    run_frame(18'h0BEEF, 18'h3CAFE, 3'd0, 18'h05000, 0, 1'b0);
  endtask

  task automatic test_done_strobe();
    run_frame(18'h00ABC, 18'h00DEF, 3'd1, 18'h06000, 24, 1'b0);
    run_frame(18'h1F00F, 18'h20002, 3'd2, 18'h07000, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_done_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
